// File: rtl/xosera_pkg.sv
// Shared copper types and sizing constants.
//   copp_instr_t      : one 32-bit copper instruction {hi word, lo word}
//   COPP_FETCH_DEPTH  : instructions the fetch stage may hold or have in flight
//   COPP_CNT_W        : width of a 0..COPP_FETCH_DEPTH occupancy count
//   COPP_WORD_W       : copper memory word width
package xosera_pkg;

  typedef logic [31:0] copp_instr_t;

  localparam int unsigned COPP_FETCH_DEPTH = 2;
  localparam int unsigned COPP_CNT_W       = $clog2(COPP_FETCH_DEPTH + 1);
  localparam int unsigned COPP_WORD_W      = 16;

endpackage

// File: rtl/copper_fetch_buf.sv
// Two-entry instruction FIFO between fetch assembly and the copper executor.
// The head entry is its own register, so the head outputs are registered and
// hold steady until a pop or a flush.
//   clk, reset_n_i        : clock, synchronous active-low reset
//   flush                 : drop all entries (beats push and pop)
//   push, push_instr/addr : enqueue one instruction and its hi-word address
//   pop                   : dequeue the head (ignored when empty)
//   head_valid/instr/addr : registered head of queue
//   count                 : entries held (0..2)
module copper_fetch_buf
  import xosera_pkg::*;
#(
  parameter int unsigned AWIDTH = 10
) (
  input  logic                  clk,
  input  logic                  reset_n_i,
  input  logic                  flush,
  input  logic                  push,
  input  copp_instr_t           push_instr,
  input  logic [AWIDTH-1:0]     push_addr,
  input  logic                  pop,
  output logic                  head_valid,
  output copp_instr_t           head_instr,
  output logic [AWIDTH-1:0]     head_addr,
  output logic [COPP_CNT_W-1:0] count
);

  localparam logic [COPP_CNT_W-1:0] FULL = COPP_CNT_W'(COPP_FETCH_DEPTH);

  copp_instr_t           tail_instr;
  logic [AWIDTH-1:0]     tail_addr;
  logic                  do_pop;
  logic                  do_push;
  logic [COPP_CNT_W-1:0] count_nxt;

  // Accept a push when full only if the head leaves in the same cycle.
  always_comb begin
    do_pop    = pop & (count != '0);
    do_push   = push & ((count != FULL) | do_pop);
    count_nxt = count + COPP_CNT_W'(do_push) - COPP_CNT_W'(do_pop);
  end

  always_ff @(posedge clk) begin
    if (!reset_n_i) begin
      count      <= '0;
      head_valid <= 1'b0;
      head_instr <= '0;
      head_addr  <= '0;
      tail_instr <= '0;
      tail_addr  <= '0;
    end else if (flush) begin
      count      <= '0;
      head_valid <= 1'b0;
    end else begin
      if (do_pop) begin
        if (count == FULL) begin
          head_instr <= tail_instr;
          head_addr  <= tail_addr;
          if (do_push) begin
            tail_instr <= push_instr;
            tail_addr  <= push_addr;
          end
        end else if (do_push) begin
          head_instr <= push_instr;
          head_addr  <= push_addr;
        end
      end else if (do_push) begin
        if (count == '0) begin
          head_instr <= push_instr;
          head_addr  <= push_addr;
        end else begin
          tail_instr <= push_instr;
          tail_addr  <= push_addr;
        end
      end
      count      <= count_nxt;
      head_valid <= (count_nxt != '0);
    end
  end

endmodule

// File: rtl/copper_fetch.sv
// Copper instruction fetch: issues word reads to copper memory, absorbs the
// one-cycle read latency, pairs even/odd words into 32-bit instructions and
// hands them to the executor over valid/ready. Restart/jump flush everything.
//   clk, reset_n_i  : clock, synchronous active-low reset
//   enable_i        : allow new reads
//   restart_i       : refetch from START_ADDR (beats jump_i)
//   jump_i, jump_addr_i : redirect to jump_addr_i (bit 0 forced to 0)
//   mem_rd_addr_o   : registered memory read address
//   mem_rd_data_i   : memory data for the address presented last cycle
//   instr_valid_o, instr_ready_i, instr_o, instr_addr_o : executor handshake
module copper_fetch
  import xosera_pkg::*;
#(
  parameter int unsigned       AWIDTH     = 10,
  parameter logic [AWIDTH-1:0] START_ADDR = '0
) (
  input  logic                   clk,
  input  logic                   reset_n_i,
  input  logic                   enable_i,
  input  logic                   restart_i,
  input  logic                   jump_i,
  input  logic [AWIDTH-1:0]      jump_addr_i,
  output logic [AWIDTH-1:0]      mem_rd_addr_o,
  input  logic [COPP_WORD_W-1:0] mem_rd_data_i,
  output logic                   instr_valid_o,
  input  logic                   instr_ready_i,
  output logic [31:0]            instr_o,
  output logic [AWIDTH-1:0]      instr_addr_o
);

  localparam int unsigned       UW         = COPP_CNT_W + 1;
  localparam logic [AWIDTH-1:0] EVEN_MASK  = ~AWIDTH'(1);
  localparam logic [AWIDTH-1:0] START_EVEN = START_ADDR & EVEN_MASK;

  logic [AWIDTH-1:0]      fptr;       // next word address to issue
  logic                   epoch;      // toggles on every redirect
  logic                   rd_v;       // address on mem_rd_addr_o is a live read
  logic                   rd_epoch;
  logic                   dat_v;      // mem_rd_data_i carries a requested word
  logic                   dat_epoch;
  logic [AWIDTH-1:0]      dat_addr;
  logic                   hi_v;
  logic [COPP_WORD_W-1:0] hi_data;
  logic [AWIDTH-1:0]      hi_addr;
  logic [COPP_CNT_W-1:0]  pend;       // instructions started but not yet buffered
  logic [COPP_CNT_W-1:0]  buf_count;

  logic                   redirect;
  logic [AWIDTH-1:0]      target;
  logic                   pop;
  logic                   word_ok;
  logic                   push;
  logic [UW-1:0]          used;
  logic                   issue;
  logic                   issue_hi;

  // Issue control. A lo word always follows its hi word; a new instruction
  // starts only while buffered + pending (less any leaving now) is below depth.
  always_comb begin
    redirect = restart_i | jump_i;
    target   = restart_i ? START_EVEN : (jump_addr_i & EVEN_MASK);
    pop      = instr_valid_o & instr_ready_i;
    word_ok  = dat_v & (dat_epoch == epoch) & ~redirect;
    push     = word_ok & dat_addr[0] & hi_v;
    used     = UW'(buf_count) + UW'(pend) - UW'(pop);
    issue    = enable_i & ~redirect & (fptr[0] | (used < UW'(COPP_FETCH_DEPTH)));
    issue_hi = issue & ~fptr[0];
  end

  // Read pointer, in-flight tags and hi-word staging.
  always_ff @(posedge clk) begin
    if (!reset_n_i) begin
      mem_rd_addr_o <= START_EVEN;
      fptr          <= START_EVEN;
      epoch         <= 1'b0;
      rd_v          <= 1'b0;
      rd_epoch      <= 1'b0;
      dat_v         <= 1'b0;
      dat_epoch     <= 1'b0;
      dat_addr      <= '0;
      hi_v          <= 1'b0;
      hi_data       <= '0;
      hi_addr       <= '0;
      pend          <= '0;
    end else begin
      dat_v     <= rd_v;
      dat_epoch <= rd_epoch;
      dat_addr  <= mem_rd_addr_o;
      if (redirect) begin
        // New epoch: whatever is still in the read pipe is dropped on arrival.
        epoch         <= ~epoch;
        mem_rd_addr_o <= target;
        fptr          <= enable_i ? target + AWIDTH'(1) : target;
        rd_v          <= enable_i;
        rd_epoch      <= ~epoch;
        hi_v          <= 1'b0;
        pend          <= COPP_CNT_W'(enable_i);
      end else begin
        rd_v     <= issue;
        rd_epoch <= epoch;
        if (issue) begin
          mem_rd_addr_o <= fptr;
          fptr          <= fptr + AWIDTH'(1);
        end
        if (word_ok && !dat_addr[0]) begin
          hi_v    <= 1'b1;
          hi_data <= mem_rd_data_i;
          hi_addr <= dat_addr;
        end else if (push) begin
          hi_v <= 1'b0;
        end
        pend <= pend + COPP_CNT_W'(issue_hi) - COPP_CNT_W'(push);
      end
    end
  end

  copper_fetch_buf #(
    .AWIDTH(AWIDTH)
  ) u_buf (
    .clk        (clk),
    .reset_n_i  (reset_n_i),
    .flush      (redirect),
    .push       (push),
    .push_instr ({hi_data, mem_rd_data_i}),
    .push_addr  (hi_addr),
    .pop        (pop),
    .head_valid (instr_valid_o),
    .head_instr (instr_o),
    .head_addr  (instr_addr_o),
    .count      (buf_count)
  );

endmodule

// File: tb/tb_copper_fetch.sv
// Directed bench for copper_fetch with a registered-read memory model.
module tb_copper_fetch;

  localparam int unsigned AW = 10;

  logic          clk = 1'b0;
  logic          reset_n_i;
  logic          enable_i;
  logic          restart_i;
  logic          jump_i;
  logic [AW-1:0] jump_addr_i;
  logic [AW-1:0] mem_rd_addr_o;
  logic [15:0]   mem_rd_data_i;
  logic          instr_valid_o;
  logic          instr_ready_i;
  logic [31:0]   instr_o;
  logic [AW-1:0] instr_addr_o;

  logic [15:0]   mem [0:(1<<AW)-1];
  int unsigned   n_pass = 0;
  int unsigned   n_total = 0;

  always #5 clk = ~clk;

  always @(posedge clk) mem_rd_data_i <= mem[mem_rd_addr_o];

  copper_fetch #(
    .AWIDTH    (AW),
    .START_ADDR(10'h000)
  ) dut (
    .clk          (clk),
    .reset_n_i    (reset_n_i),
    .enable_i     (enable_i),
    .restart_i    (restart_i),
    .jump_i       (jump_i),
    .jump_addr_i  (jump_addr_i),
    .mem_rd_addr_o(mem_rd_addr_o),
    .mem_rd_data_i(mem_rd_data_i),
    .instr_valid_o(instr_valid_o),
    .instr_ready_i(instr_ready_i),
    .instr_o      (instr_o),
    .instr_addr_o (instr_addr_o)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] exp_instr(input logic [AW-1:0] a);
    logic [AW-1:0] b;
    b = a + 10'd1;
    return {mem[a], mem[b]};
  endfunction

  task automatic test_reset();
    reset_n_i = 1'b0; enable_i = 1'b0; restart_i = 1'b0; jump_i = 1'b0;
    jump_addr_i = '0; instr_ready_i = 1'b1;
    tick(); tick();
    n_total++; if (mem_rd_addr_o !== 10'h000) $display("FAIL reset_rd_addr: got %h want 000", mem_rd_addr_o); else n_pass++;
    n_total++; if (instr_valid_o !== 1'b0) $display("FAIL reset_valid: got %b want 0", instr_valid_o); else n_pass++;
    n_total++; if (instr_o !== 32'h0) $display("FAIL reset_instr: got %h want 0", instr_o); else n_pass++;
    n_total++; if (instr_addr_o !== 10'h000) $display("FAIL reset_instr_addr: got %h want 000", instr_addr_o); else n_pass++;
    reset_n_i = 1'b1;
    tick(); tick();
    n_total++; if (instr_valid_o !== 1'b0) $display("FAIL idle_valid: got %b want 0", instr_valid_o); else n_pass++;
  endtask

  task automatic test_restart();
    logic exp_v [1:6];
    exp_v = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    enable_i = 1'b1; instr_ready_i = 1'b1; restart_i = 1'b1;
    tick();
    restart_i = 1'b0;
    n_total++; if (mem_rd_addr_o !== 10'h000) $display("FAIL restart_rd_addr: got %h want 000", mem_rd_addr_o); else n_pass++;
    for (int k = 1; k <= 6; k++) begin
      if (k > 1) tick();
      n_total++;
      if (instr_valid_o !== exp_v[k]) $display("FAIL restart_valid_n%0d: got %b want %b", k, instr_valid_o, exp_v[k]); else n_pass++;
    end
    // now at restart+6; restart+4 delivered @0, this one @2
    n_total++; if (instr_o !== 32'h33334444) $display("FAIL restart_instr2: got %h want 33334444", instr_o); else n_pass++;
    n_total++; if (instr_addr_o !== 10'h002) $display("FAIL restart_addr2: got %h want 002", instr_addr_o); else n_pass++;
  endtask

  task automatic test_restart_first();
    enable_i = 1'b1; instr_ready_i = 1'b1; restart_i = 1'b1;
    tick();
    restart_i = 1'b0;
    tick(); tick(); tick();
    n_total++; if (instr_valid_o !== 1'b1) $display("FAIL first_valid: got %b want 1", instr_valid_o); else n_pass++;
    n_total++; if (instr_o !== 32'h11112222) $display("FAIL first_instr: got %h want 11112222", instr_o); else n_pass++;
    n_total++; if (instr_addr_o !== 10'h000) $display("FAIL first_addr: got %h want 000", instr_addr_o); else n_pass++;
  endtask

  task automatic test_stall();
    logic [31:0]   s_instr;
    logic [AW-1:0] s_rd;
    logic          exp_v [0:6];
    logic [AW-1:0] exp_a [0:6];
    exp_v = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    exp_a = '{10'h000, 10'h002, 10'h000, 10'h000, 10'h004, 10'h000, 10'h006};
    enable_i = 1'b1; instr_ready_i = 1'b0; restart_i = 1'b1;
    tick();
    restart_i = 1'b0;
    repeat (9) tick();
    s_instr = instr_o;
    s_rd    = mem_rd_addr_o;
    repeat (10) tick();
    n_total++; if (instr_valid_o !== 1'b1) $display("FAIL stall_valid: got %b want 1", instr_valid_o); else n_pass++;
    n_total++; if (instr_o !== s_instr || instr_o !== 32'h11112222) $display("FAIL stall_instr_stable: got %h want 11112222", instr_o); else n_pass++;
    n_total++; if (instr_addr_o !== 10'h000) $display("FAIL stall_addr: got %h want 000", instr_addr_o); else n_pass++;
    n_total++; if (mem_rd_addr_o !== s_rd || mem_rd_addr_o !== 10'h003) $display("FAIL stall_rd_addr: got %h want 003", mem_rd_addr_o); else n_pass++;
    instr_ready_i = 1'b1;
    for (int k = 0; k <= 6; k++) begin
      n_total++;
      if (instr_valid_o !== exp_v[k]) $display("FAIL drain_valid_%0d: got %b want %b", k, instr_valid_o, exp_v[k]); else n_pass++;
      if (exp_v[k]) begin
        n_total++;
        if (instr_addr_o !== exp_a[k] || instr_o !== exp_instr(exp_a[k]))
          $display("FAIL drain_data_%0d: got %h@%h want %h@%h", k, instr_o, instr_addr_o, exp_instr(exp_a[k]), exp_a[k]);
        else n_pass++;
      end
      tick();
    end
  endtask

  task automatic test_jump();
    enable_i = 1'b1; instr_ready_i = 1'b0; restart_i = 1'b1;
    tick();
    restart_i = 1'b0;
    repeat (19) tick();
    jump_addr_i = 10'h101; jump_i = 1'b1;
    tick();
    jump_i = 1'b0;
    n_total++; if (mem_rd_addr_o !== 10'h100) $display("FAIL jump_rd_addr: got %h want 100", mem_rd_addr_o); else n_pass++;
    for (int k = 1; k <= 3; k++) begin
      if (k > 1) tick();
      n_total++; if (instr_valid_o !== 1'b0) $display("FAIL jump_flush_n%0d: got %b want 0", k, instr_valid_o); else n_pass++;
    end
    tick();
    n_total++;
    if (instr_valid_o !== 1'b1 || instr_addr_o !== 10'h100 || instr_o !== exp_instr(10'h100))
      $display("FAIL jump_first: got v=%b %h@%h want v=1 %h@100", instr_valid_o, instr_o, instr_addr_o, exp_instr(10'h100));
    else n_pass++;
    instr_ready_i = 1'b1;
    tick();
    // a read is in flight here; jump again and the 0x102 instruction must vanish
    n_total++; if (instr_valid_o !== 1'b0) $display("FAIL jump2_pre: got %b want 0", instr_valid_o); else n_pass++;
    jump_addr_i = 10'h200; jump_i = 1'b1;
    tick();
    jump_i = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      if (k > 1) tick();
      n_total++; if (instr_valid_o !== 1'b0) $display("FAIL jump2_flush_n%0d: got %b want 0", k, instr_valid_o); else n_pass++;
    end
    tick();
    n_total++;
    if (instr_valid_o !== 1'b1 || instr_addr_o !== 10'h200 || instr_o !== exp_instr(10'h200))
      $display("FAIL jump2_first: got v=%b %h@%h want v=1 %h@200", instr_valid_o, instr_o, instr_addr_o, exp_instr(10'h200));
    else n_pass++;
  endtask

  task automatic test_wrap();
    logic [AW-1:0] exp_a [0:2];
    exp_a = '{10'h3FE, 10'h000, 10'h002};
    enable_i = 1'b1; instr_ready_i = 1'b1;
    jump_addr_i = 10'h3FE; jump_i = 1'b1;
    tick();
    jump_i = 1'b0;
    n_total++; if (mem_rd_addr_o !== 10'h3FE) $display("FAIL wrap_rd_addr: got %h want 3fe", mem_rd_addr_o); else n_pass++;
    tick(); tick();
    for (int k = 0; k < 3; k++) begin
      tick();
      n_total++;
      if (instr_valid_o !== 1'b1 || instr_addr_o !== exp_a[k] || instr_o !== exp_instr(exp_a[k]))
        $display("FAIL wrap_%0d: got v=%b %h@%h want v=1 %h@%h", k, instr_valid_o, instr_o, instr_addr_o, exp_instr(exp_a[k]), exp_a[k]);
      else n_pass++;
      tick();
    end
  endtask

  task automatic test_priority();
    enable_i = 1'b1; instr_ready_i = 1'b1;
    jump_addr_i = 10'h200; jump_i = 1'b1; restart_i = 1'b1;
    tick();
    jump_i = 1'b0; restart_i = 1'b0;
    n_total++; if (mem_rd_addr_o !== 10'h000) $display("FAIL prio_rd_addr: got %h want 000", mem_rd_addr_o); else n_pass++;
    tick(); tick(); tick();
    n_total++;
    if (instr_valid_o !== 1'b1 || instr_addr_o !== 10'h000 || instr_o !== 32'h11112222)
      $display("FAIL prio_first: got v=%b %h@%h want v=1 11112222@000", instr_valid_o, instr_o, instr_addr_o);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    enable_i = 1'b1; instr_ready_i = 1'b1;
    jump_addr_i = 10'h104; jump_i = 1'b1;
    tick();
    jump_i = 1'b0;
    tick(); tick();
    // hi word is staged, lo word is on the bus
    reset_n_i = 1'b0;
    tick();
    n_total++; if (mem_rd_addr_o !== 10'h000) $display("FAIL rstmid_rd_addr: got %h want 000", mem_rd_addr_o); else n_pass++;
    n_total++; if (instr_valid_o !== 1'b0) $display("FAIL rstmid_valid: got %b want 0", instr_valid_o); else n_pass++;
    n_total++; if (instr_o !== 32'h0) $display("FAIL rstmid_instr: got %h want 0", instr_o); else n_pass++;
    n_total++; if (instr_addr_o !== 10'h000) $display("FAIL rstmid_addr: got %h want 000", instr_addr_o); else n_pass++;
    reset_n_i = 1'b1;
    enable_i = 1'b0;
    tick(); tick(); tick();
    n_total++; if (instr_valid_o !== 1'b0) $display("FAIL rstmid_nopush: got %b want 0", instr_valid_o); else n_pass++;
  endtask

  task automatic test_enable_random();
    logic [AW-1:0] exp_a;
    int unsigned   xfers;
    logic          hold;
    logic [31:0]   h_instr;
    logic [AW-1:0] h_addr;
    exp_a = '0; xfers = 0; hold = 1'b0; h_instr = '0; h_addr = '0;
    enable_i = 1'b1; instr_ready_i = 1'b1; restart_i = 1'b1;
    tick();
    restart_i = 1'b0;
    for (int c = 0; c < 400; c++) begin
      enable_i      = ($urandom_range(0, 1) == 1);
      instr_ready_i = ($urandom_range(0, 9) < 7);
      if (hold) begin
        n_total++;
        if (instr_valid_o !== 1'b1 || instr_o !== h_instr || instr_addr_o !== h_addr)
          $display("FAIL rnd_hold_c%0d: got v=%b %h@%h want v=1 %h@%h", c, instr_valid_o, instr_o, instr_addr_o, h_instr, h_addr);
        else n_pass++;
      end
      if (instr_valid_o === 1'b1 && instr_ready_i) begin
        n_total++;
        if (instr_addr_o !== exp_a || instr_o !== exp_instr(exp_a))
          $display("FAIL rnd_seq_%0d: got %h@%h want %h@%h", xfers, instr_o, instr_addr_o, exp_instr(exp_a), exp_a);
        else n_pass++;
        exp_a = exp_a + 10'd2;
        xfers++;
      end
      hold    = (instr_valid_o === 1'b1) && !instr_ready_i;
      h_instr = instr_o;
      h_addr  = instr_addr_o;
      tick();
    end
    n_total++; if (xfers < 20) $display("FAIL rnd_progress: got %0d transfers want >= 20", xfers); else n_pass++;
  endtask

  initial begin
    for (int i = 0; i < (1 << AW); i++) mem[i] = 16'hC000 | 16'(i);
    mem[0] = 16'h1111; mem[1] = 16'h2222; mem[2] = 16'h3333; mem[3] = 16'h4444;
    test_reset();
    test_restart_first();
    test_restart();
    test_stall();
    test_jump();
    test_wrap();
    test_priority();
    test_reset_mid();
    test_enable_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
